// File: rtl/ddr3_init_sequencer_if.sv
// DFI command/control bundle driven by the DDR3 init sequencer toward the DFI mux.
interface ddr3_init_sequencer_if #(
   parameter int RANKS  = 1,
   parameter int ADDR_W = 14
);
   logic              dfi_reset_n;
   logic [RANKS-1:0]  dfi_cke;
   logic [RANKS-1:0]  dfi_cs_n;
   logic              dfi_ras_n;
   logic              dfi_cas_n;
   logic              dfi_we_n;
   logic [2:0]        dfi_bank;
   logic [ADDR_W-1:0] dfi_address;
   logic [RANKS-1:0]  dfi_odt;

   modport master (
      output dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
             dfi_bank, dfi_address, dfi_odt
   );
   modport slave (
      input  dfi_reset_n, dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n,
             dfi_bank, dfi_address, dfi_odt
   );
endinterface

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MRS2/3/1/0 per rank, then done.
// Define DDR_INIT_ZQCL_EN to append a per-rank ZQCL + tZQinit before done.
module ddr3_init_sequencer #(
   parameter int CLK_PERIOD_PS = 2500,
   parameter int T_RESET_NS    = 200000,
   parameter int T_CKE_NS      = 500000,
   parameter int T_XPR_NS      = 270,
   parameter int T_MRD_CK      = 4,
   parameter int T_MOD_CK      = 12,
   parameter int T_ZQINIT_CK   = 512,
   parameter int RANKS         = 1,
   parameter int ADDR_W        = 14
) (
   input  logic              core_clk,
   input  logic              core_arstn,
   input  logic              ddr_init_start,
   output logic              ddr_init_done,
   output logic              ddr_init_busy,
   input  logic [ADDR_W-1:0] cfg_mr0,
   input  logic [ADDR_W-1:0] cfg_mr1,
   input  logic [ADDR_W-1:0] cfg_mr2,
   input  logic [ADDR_W-1:0] cfg_mr3,
   ddr3_init_sequencer_if.master dfi
);

   function automatic int max1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int ns2ck(input longint ns);
      longint c;
      c = (ns * longint'(1000) + longint'(CLK_PERIOD_PS) - longint'(1)) / longint'(CLK_PERIOD_PS);
      return (c < longint'(1)) ? 1 : int'(c);
   endfunction

   // Wait-state lengths in cycles; the command cycle itself counts toward tMRD/tMOD/tZQinit.
   localparam int C_RESET = ns2ck(longint'(T_RESET_NS));
   localparam int C_CKE   = ns2ck(longint'(T_CKE_NS));
   localparam int C_XPR   = ns2ck(longint'(T_XPR_NS));
   localparam int C_MRDW  = max1(T_MRD_CK - 1);
   localparam int C_MODW  = max1(T_MOD_CK - 1);
`ifdef DDR_INIT_ZQCL_EN
   localparam int C_ZQW   = max1(T_ZQINIT_CK - 1);
`else
   localparam int C_ZQW   = 1;
`endif
   localparam int C_MAX   = max2(max2(max2(C_RESET, C_CKE), max2(C_XPR, C_MRDW)),
                                 max2(C_MODW, C_ZQW));
   localparam int CW      = $clog2(C_MAX) + 1;
   localparam int RW      = (RANKS > 1) ? $clog2(RANKS) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_LOW,
      S_CKE_WAIT,
      S_XPR,
      S_MRS,
      S_MRS_WAIT,
`ifdef DDR_INIT_ZQCL_EN
      S_ZQCL,
      S_ZQ_WAIT,
`endif
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]     rank_q, rank_d;
   logic [1:0]        step_q, step_d;   // 0..3 -> MR2, MR3, MR1, MR0
   logic              cnt_zero, last_rank;

   logic              reset_n_q, reset_n_d;
   logic [RANKS-1:0]  cke_q, cke_d;
   logic [RANKS-1:0]  cs_n_q, cs_n_d;
   logic              ras_n_q, ras_n_d;
   logic              cas_n_q, cas_n_d;
   logic              we_n_q, we_n_d;
   logic [2:0]        bank_q, bank_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   always_ff @(posedge core_clk or negedge core_arstn) begin
      if (!core_arstn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rank_q    <= '0;
         step_q    <= '0;
         reset_n_q <= 1'b0;
         cke_q     <= '0;
         cs_n_q    <= '1;
         ras_n_q   <= 1'b1;
         cas_n_q   <= 1'b1;
         we_n_q    <= 1'b1;
         bank_q    <= '0;
         addr_q    <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rank_q    <= rank_d;
         step_q    <= step_d;
         reset_n_q <= reset_n_d;
         cke_q     <= cke_d;
         cs_n_q    <= cs_n_d;
         ras_n_q   <= ras_n_d;
         cas_n_q   <= cas_n_d;
         we_n_q    <= we_n_d;
         bank_q    <= bank_d;
         addr_q    <= addr_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rank_d    = rank_q;
      step_d    = step_q;
      cnt_zero  = (cnt_q == '0);
      last_rank = (rank_q == RW'(RANKS - 1));

      case (state_q)
         S_IDLE: begin
            if (ddr_init_start) begin
               state_d = S_RST_LOW;
               cnt_d   = CW'(C_RESET - 1);
            end
         end
         S_RST_LOW: begin
            if (cnt_zero) begin
               state_d = S_CKE_WAIT;
               cnt_d   = CW'(C_CKE - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_CKE_WAIT: begin
            if (cnt_zero) begin
               state_d = S_XPR;
               cnt_d   = CW'(C_XPR - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_XPR: begin
            if (cnt_zero) begin
               state_d = S_MRS;
               rank_d  = '0;
               step_d  = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_MRS: begin
            state_d = S_MRS_WAIT;
            cnt_d   = (step_q == 2'd3) ? CW'(C_MODW - 1) : CW'(C_MRDW - 1);
         end
         S_MRS_WAIT: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CW'(1);
            end else if (step_q != 2'd3) begin
               state_d = S_MRS;
               step_d  = step_q + 2'd1;
            end else if (!last_rank) begin
               state_d = S_MRS;
               step_d  = '0;
               rank_d  = rank_q + RW'(1);
            end else begin
`ifdef DDR_INIT_ZQCL_EN
               state_d = S_ZQCL;
               rank_d  = '0;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef DDR_INIT_ZQCL_EN
         S_ZQCL: begin
            state_d = S_ZQ_WAIT;
            cnt_d   = CW'(C_ZQW - 1);
         end
         S_ZQ_WAIT: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!last_rank) begin
               state_d = S_ZQCL;
               rank_d  = rank_q + RW'(1);
            end else begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      reset_n_d = 1'b1;
      cke_d     = '1;
      cs_n_d    = '1;
      ras_n_d   = 1'b1;
      cas_n_d   = 1'b1;
      we_n_d    = 1'b1;
      bank_d    = '0;
      addr_d    = '0;
      case (state_d)
         S_IDLE, S_RST_LOW: begin
            reset_n_d = 1'b0;
            cke_d     = '0;
         end
         S_CKE_WAIT: cke_d = '0;
         S_MRS: begin
            cs_n_d  = ~(RANKS'(1) << rank_d);
            ras_n_d = 1'b0;
            cas_n_d = 1'b0;
            we_n_d  = 1'b0;
            case (step_d)
               2'd0:    begin bank_d = 3'd2; addr_d = cfg_mr2; end
               2'd1:    begin bank_d = 3'd3; addr_d = cfg_mr3; end
               2'd2:    begin bank_d = 3'd1; addr_d = cfg_mr1; end
               default: begin bank_d = 3'd0; addr_d = cfg_mr0; end
            endcase
         end
`ifdef DDR_INIT_ZQCL_EN
         S_ZQCL: begin
            cs_n_d     = ~(RANKS'(1) << rank_d);
            we_n_d     = 1'b0;
            addr_d[10] = 1'b1;
         end
`endif
         default: ;
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   assign ddr_init_done   = done_q;
   assign ddr_init_busy   = busy_q;
   assign dfi.dfi_reset_n = reset_n_q;
   assign dfi.dfi_cke     = cke_q;
   assign dfi.dfi_cs_n    = cs_n_q;
   assign dfi.dfi_ras_n   = ras_n_q;
   assign dfi.dfi_cas_n   = cas_n_q;
   assign dfi.dfi_we_n    = we_n_q;
   assign dfi.dfi_bank    = bank_q;
   assign dfi.dfi_address = addr_q;
   assign dfi.dfi_odt     = '0;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: 1-rank and 2-rank instances checked every cycle
// against a timeline model derived from the init timing rules.
module tb_ddr3_init_sequencer;
   localparam int PER    = 1000;
   localparam int R_CK   = (20 * 1000 + PER - 1) / PER;
   localparam int C_CK   = (50 * 1000 + PER - 1) / PER;
   localparam int X_CK   = (5 * 1000 + PER - 1) / PER;
   localparam int MRD    = 4;
   localparam int MOD    = 12;
   localparam int ZQI    = 32;
   localparam int MRS_T0 = R_CK + C_CK + X_CK + 1;
   localparam int SPAN   = 3 * MRD + MOD;
`ifdef DDR_INIT_ZQCL_EN
   localparam bit ZQ_ON  = 1'b1;
`else
   localparam bit ZQ_ON  = 1'b0;
`endif
   // Hand-derived landmarks (cycles after the start edge) for the bench timings.
   localparam int LIT_FIRST_MRS = 76;
   localparam int LIT_R1_MRS    = 100;
   localparam int LIT_DONE0     = ZQ_ON ? 132 : 100;
   localparam int LIT_DONE1     = ZQ_ON ? 188 : 124;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic start = 1'b0;
   logic [13:0] mr0 = '0, mr1 = '0, mr2 = '0, mr3 = '0;
   logic done0, busy0, done1, busy1;

   always #5 clk = ~clk;

   ddr3_init_sequencer_if #(.RANKS(1), .ADDR_W(14)) if0 ();
   ddr3_init_sequencer_if #(.RANKS(2), .ADDR_W(14)) if1 ();

   ddr3_init_sequencer #(
      .CLK_PERIOD_PS(1000), .T_RESET_NS(20), .T_CKE_NS(50), .T_XPR_NS(5),
      .T_MRD_CK(4), .T_MOD_CK(12), .T_ZQINIT_CK(32), .RANKS(1), .ADDR_W(14)
   ) u_dut0 (
      .core_clk(clk), .core_arstn(rstn), .ddr_init_start(start),
      .ddr_init_done(done0), .ddr_init_busy(busy0),
      .cfg_mr0(mr0), .cfg_mr1(mr1), .cfg_mr2(mr2), .cfg_mr3(mr3),
      .dfi(if0)
   );

   ddr3_init_sequencer #(
      .CLK_PERIOD_PS(1000), .T_RESET_NS(20), .T_CKE_NS(50), .T_XPR_NS(5),
      .T_MRD_CK(4), .T_MOD_CK(12), .T_ZQINIT_CK(32), .RANKS(2), .ADDR_W(14)
   ) u_dut1 (
      .core_clk(clk), .core_arstn(rstn), .ddr_init_start(start),
      .ddr_init_done(done1), .ddr_init_busy(busy1),
      .cfg_mr0(mr0), .cfg_mr1(mr1), .cfg_mr2(mr2), .cfg_mr3(mr3),
      .dfi(if1)
   );

   // Expected output word {done,busy,reset_n,cke[4],cs_n[4],ras,cas,we,bank,addr,odt[4]}
   // at k cycles after the start edge, from the phase boundaries.
   function automatic logic [34:0] model(input int nr, input bit st, input int k,
                                         input logic [13:0] m0, input logic [13:0] m1,
                                         input logic [13:0] m2, input logic [13:0] m3);
      logic rn, dn, bz;
      logic [3:0] msk, ck, cs;
      logic [2:0] cmd, ba;
      logic [13:0] ad;
      int mend, dt, off, r, j;
      msk = (nr == 1) ? 4'b0001 : 4'b0011;
      rn = 1'b0; ck = 4'b0; cs = msk; cmd = 3'b111; ba = 3'd0; ad = 14'd0;
      dn = 1'b0; bz = 1'b0;
      if (st) begin
         mend = MRS_T0 + nr * SPAN;
         dt   = mend + (ZQ_ON ? nr * ZQI : 0);
         rn   = (k > R_CK);
         ck   = (k > R_CK + C_CK) ? msk : 4'b0;
         dn   = (k >= dt);
         bz   = ~dn;
         if (k >= MRS_T0 && k < mend) begin
            off = k - MRS_T0;
            r   = off / SPAN;
            j   = off % SPAN;
            if (j % MRD == 0 && j / MRD < 4) begin
               cs  = msk & ~(4'b0001 << r);
               cmd = 3'b000;
               case (j / MRD)
                  0:       begin ba = 3'd2; ad = m2; end
                  1:       begin ba = 3'd3; ad = m3; end
                  2:       begin ba = 3'd1; ad = m1; end
                  default: begin ba = 3'd0; ad = m0; end
               endcase
            end
         end
         if (ZQ_ON && k >= mend && k < dt && (k - mend) % ZQI == 0) begin
            r   = (k - mend) / ZQI;
            cs  = msk & ~(4'b0001 << r);
            cmd = 3'b110;
            ad  = 14'h0400;
         end
      end
      return {dn, bz, rn, ck, cs, cmd, ba, ad, 4'b0000};
   endfunction

   int cyc = 0;
   int t0 = 0;
   bit started = 1'b0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         started <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (!started && start) begin
            started <= 1'b1;
            t0      <= cyc;
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   int fc0 = -1, fc1 = -1, dk0 = -1, dk1 = -1;

   task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp, input int k);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s k=%0d got=%h exp=%h", name, k, act, exp);
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", name, act, exp);
   endtask

   // Single compare process: every falling clock edge, and just after any reset assertion.
   always @(negedge clk or negedge rstn) begin
      logic [34:0] a0, a1, e0, e1;
      int k;
      #1;
      k  = cyc - t0;
      e0 = model(1, started, k, mr0, mr1, mr2, mr3);
      e1 = model(2, started, k, mr0, mr1, mr2, mr3);
      a0 = {done0, busy0, if0.dfi_reset_n, 3'b000, if0.dfi_cke, 3'b000, if0.dfi_cs_n,
            if0.dfi_ras_n, if0.dfi_cas_n, if0.dfi_we_n, if0.dfi_bank, if0.dfi_address,
            3'b000, if0.dfi_odt};
      a1 = {done1, busy1, if1.dfi_reset_n, 2'b00, if1.dfi_cke, 2'b00, if1.dfi_cs_n,
            if1.dfi_ras_n, if1.dfi_cas_n, if1.dfi_we_n, if1.dfi_bank, if1.dfi_address,
            2'b00, if1.dfi_odt};
      chk("rank1_outputs", a0, e0, k);
      chk("rank2_outputs", a1, e1, k);
      if (started && rstn) begin
         if (k == 1) begin
            fc0 = -1; fc1 = -1; dk0 = -1; dk1 = -1;
         end
         if (fc0 < 0 && !if0.dfi_cs_n[0]) begin
            fc0 = k;
            chk_i("first_mrs_cycle", fc0, LIT_FIRST_MRS);
         end
         if (fc1 < 0 && !if1.dfi_cs_n[1]) begin
            fc1 = k;
            chk_i("rank1_first_mrs_cycle", fc1, LIT_R1_MRS);
         end
         if (dk0 < 0 && done0) begin
            dk0 = k;
            chk_i("rank1_done_cycle", dk0, LIT_DONE0);
         end
         if (dk1 < 0 && done1) begin
            dk1 = k;
            chk_i("rank2_done_cycle", dk1, LIT_DONE1);
         end
      end
   end

   task automatic pulse_start();
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wander start randomly while busy until the 2-rank instance finishes.
   task automatic run_to_done();
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (done1) return;
         start = 1'($urandom_range(0, 1));
      end
      $display("FAIL done_timeout got=0 exp=1");
      $fatal(1, "init sequence never completed");
   endtask

   task automatic hold_done(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 start = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic new_cfg();
      mr0 = 14'($urandom);
      mr1 = 14'($urandom);
      mr2 = 14'($urandom);
      mr3 = 14'($urandom);
   endtask

   initial begin
      new_cfg();
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (100) @(posedge clk);

      // full sequence with start wandering while busy and after done
      repeat ($urandom_range(1, 7)) @(posedge clk);
      pulse_start();
      run_to_done();
      hold_done(25);

      // fresh config, start, then async reset in the middle of the MRS phase
      @(posedge clk);
      #2 rstn = 1'b0;
      start = 1'b0;
      new_cfg();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (10) @(posedge clk);
      pulse_start();
      repeat (80) @(posedge clk);
      #2 rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat ($urandom_range(3, 9)) @(posedge clk);

      // replay from RST_LOW after the interrupted run
      pulse_start();
      run_to_done();
      hold_done(30);

      @(negedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
